pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset, with ports: i_clk  in  1  rising-edge clock; i_reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- i_enable  in  1  pipeline advance enable from the debug unit; 0 freezes everything.
- i_load_hazard  in  1  load-use hazard request from risk_detection.
- i_jmp_req  in  1  jump-stop request from risk_detection.
- i_halt  in  1  HALT opcode detected in IF/ID.
REQ-003 The block SHALL have these outputs:
- o_pc_wr_en  out  1  PC write enable.
- o_if_id_wr_en  out  1  IF/ID register write enable.
- o_if_id_flush  out  1  load NOP into IF/ID.
- o_id_ex_bubble  out  1  force control signals of ID/EX to zero.
- o_jmp_stop  out  1  registered jump-stop feedback to risk_detection i_jmp_stop.
- o_halted  out  1  program finished, pipeline drained.
- o_load_stall_cnt  out  16  load-stall cycle count.
- o_jmp_stall_cnt  out  16  jump-stall cycle count.
- o_cycle_cnt  out  32  enabled run cycles.

Function
REQ-004 The block SHALL implement the FSM states RUN, JMP_WAIT, DRAIN and HALTED, and SHALL transition only on rising i_clk edges with i_enable=1 (reset excepted).
REQ-005 When i_enable=0, the block SHALL drive o_pc_wr_en=0, o_if_id_wr_en=0, o_if_id_flush=0 and o_id_ex_bubble=0, and SHALL hold state, drain counter and all counters.
REQ-006 In RUN with no request, the block SHALL drive o_pc_wr_en=1, o_if_id_wr_en=1, o_if_id_flush=0 and o_id_ex_bubble=0.
REQ-007 Priority per cycle in RUN SHALL be: i_halt > i_load_hazard > i_jmp_req.
REQ-008 Load hazard (RUN): in the same cycle, combinationally, the block SHALL drive o_pc_wr_en=0, o_if_id_wr_en=0 and o_id_ex_bubble=1, and SHALL remain in RUN; the stall lasts exactly as long as i_load_hazard is high.
REQ-009 Jump request (RUN): the block SHALL drive o_pc_wr_en=0 and o_if_id_wr_en=0 in the same cycle, then go to JMP_WAIT with o_jmp_stop registered to 1.
REQ-010 In JMP_WAIT, the block SHALL drive o_jmp_stop=1 and all write enables=1, and SHALL return to RUN next enabled cycle with o_jmp_stop cleared; i_jmp_req is ignored in JMP_WAIT.
REQ-011 Halt (RUN): the block SHALL drive o_pc_wr_en=0 and o_if_id_wr_en=1 with o_if_id_flush=1 in the same cycle, load the drain counter with 3, and go to DRAIN.
REQ-012 In DRAIN, the block SHALL drive o_pc_wr_en=0 and o_if_id_flush=1, and SHALL decrement the drain counter per enabled cycle; when the counter is 0, it SHALL go to HALTED.
REQ-013 In HALTED, the block SHALL drive o_halted=1 and all enables=0; it SHALL leave HALTED only by reset.
REQ-014 The block SHALL ignore i_load_hazard, i_jmp_req and i_halt in DRAIN and HALTED.
REQ-015 o_jmp_stop and o_halted SHALL be registered; all other control outputs SHALL be combinational from state and inputs.

Reset
REQ-016 When i_reset=1 at a clock edge, the block SHALL set state=RUN, drain counter=0, o_jmp_stop=0, o_halted=0 and all counters=0, regardless of i_enable or current state, including mid-DRAIN.
REQ-017 While i_reset is asserted, the block SHALL drive o_pc_wr_en=0, o_if_id_wr_en=0, o_if_id_flush=0 and o_id_ex_bubble=0.

Configuration
REQ-018 Macro HAZARD_STALL_CNT_EN defined: the block SHALL increment o_load_stall_cnt per enabled load-stall cycle, o_jmp_stall_cnt per enabled jump-request cycle in RUN, and o_cycle_cnt per enabled cycle not in HALTED; all three SHALL saturate at all-ones.
REQ-019 Macro HAZARD_STALL_CNT_EN undefined: the three counter ports SHALL remain present and be tied to 0, with no counter flops.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, then i_enable=1, no requests for 5 cycles -> pc/if_id enables=1, bubble=0, o_cycle_cnt=5 (macro on).
- i_load_hazard=1 for 2 cycles -> o_pc_wr_en=0 and o_id_ex_bubble=1 for exactly those 2 cycles, o_load_stall_cnt=2.
- i_jmp_req=1 for 1 cycle -> o_pc_wr_en=0 that cycle, o_jmp_stop=1 next cycle only, then RUN enables=1.
- i_halt=1 together with i_load_hazard=1 -> halt wins, bubble=0, o_halted=1 exactly 4 enabled cycles later and held.
- i_enable=0 mid-DRAIN for 3 cycles -> state and drain counter frozen, o_halted delayed by 3 cycles.
- i_reset=1 while HALTED -> o_halted=0, counters=0, RUN enables next cycle; with macro off, all counters read 0 throughout.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Pipeline hazard controller. Arbitrates halt, load-use and
//               jump-stop requests into PC / IF/ID / ID/EX control, sequences
//               the halt drain and optionally counts stall and run cycles.
//               Optional feature macro: HAZARD_STALL_CNT_EN (performance
//               counters; when undefined the counter ports read 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_load_hazard,
  input  logic        i_jmp_req,
  input  logic        i_halt,
  output logic        o_pc_wr_en,
  output logic        o_if_id_wr_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_bubble,
  output logic        o_jmp_stop,
  output logic        o_halted,
  output logic [15:0] o_load_stall_cnt,
  output logic [15:0] o_jmp_stall_cnt,
  output logic [31:0] o_cycle_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_JMP_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // Pipeline stages still holding live instructions behind the HALT.
  localparam logic [1:0] C_DRAIN_LOAD = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       jmp_stop_q, jmp_stop_d;
  logic       halted_q, halted_d;

  // Next-state and combinational pipeline controls; reset and a frozen
  // pipeline both force every enable low and hold all state.
  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    o_pc_wr_en     = 1'b0;
    o_if_id_wr_en  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;

    if (!i_reset && i_enable) begin
      case (state_q)
        ST_RUN: begin
          if (i_halt) begin
            // Stop fetching, replace the HALT in IF/ID with a NOP and let
            // the instructions ahead of it retire.
            o_if_id_wr_en = 1'b1;
            o_if_id_flush = 1'b1;
            drain_cnt_d   = C_DRAIN_LOAD;
            state_d       = ST_DRAIN;
          end else if (i_load_hazard) begin
            // Hold PC and IF/ID, inject a bubble; lasts while request is high.
            o_id_ex_bubble = 1'b1;
          end else if (i_jmp_req) begin
            // Hold fetch this cycle; the registered jump-stop is raised next.
            state_d = ST_JMP_WAIT;
          end else begin
            o_pc_wr_en    = 1'b1;
            o_if_id_wr_en = 1'b1;
          end
        end

        ST_JMP_WAIT: begin
          // Jump target is resolved; resume fetch, further requests ignored.
          o_pc_wr_en    = 1'b1;
          o_if_id_wr_en = 1'b1;
          state_d       = ST_RUN;
        end

        ST_DRAIN: begin
          // Keep flushing IF/ID so nothing new enters behind the HALT.
          o_if_id_wr_en = 1'b1;
          o_if_id_flush = 1'b1;
          if (drain_cnt_q == 2'd0) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end

        ST_HALTED: begin
          state_d = ST_HALTED;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    // Registered status flags track the state being entered, so they hold
    // naturally whenever the state itself holds.
    jmp_stop_d = (state_d == ST_JMP_WAIT);
    halted_d   = (state_d == ST_HALTED);
  end

  // State, drain counter and registered status flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      jmp_stop_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      jmp_stop_q  <= jmp_stop_d;
      halted_q    <= halted_d;
    end
  end

  assign o_jmp_stop = jmp_stop_q;
  assign o_halted   = halted_q;

`ifdef HAZARD_STALL_CNT_EN
  logic        w_active;
  logic        w_load_stall;
  logic        w_jmp_take;
  logic        w_run_cycle;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] jmp_cnt_q, jmp_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Count events as the arbitration above resolves them; saturate at all-ones.
  always_comb begin
    w_active     = i_enable && (state_q == ST_RUN);
    w_load_stall = w_active && !i_halt && i_load_hazard;
    w_jmp_take   = w_active && !i_halt && !i_load_hazard && i_jmp_req;
    w_run_cycle  = i_enable && (state_q != ST_HALTED);

    load_cnt_d  = load_cnt_q;
    jmp_cnt_d   = jmp_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (w_load_stall && !(&load_cnt_q)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    if (w_jmp_take && !(&jmp_cnt_q)) begin
      jmp_cnt_d = jmp_cnt_q + 16'd1;
    end
    if (w_run_cycle && !(&cycle_cnt_q)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      load_cnt_q  <= 16'd0;
      jmp_cnt_q   <= 16'd0;
      cycle_cnt_q <= 32'd0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      jmp_cnt_q   <= jmp_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign o_load_stall_cnt = load_cnt_q;
  assign o_jmp_stall_cnt  = jmp_cnt_q;
  assign o_cycle_cnt      = cycle_cnt_q;
`else
  assign o_load_stall_cnt = 16'd0;
  assign o_jmp_stall_cnt  = 16'd0;
  assign o_cycle_cnt      = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
//               Counter expectations scale with HAZARD_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_STALL_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_load_hazard;
  logic        i_jmp_req;
  logic        i_halt;
  logic        o_pc_wr_en;
  logic        o_if_id_wr_en;
  logic        o_if_id_flush;
  logic        o_id_ex_bubble;
  logic        o_jmp_stop;
  logic        o_halted;
  logic [15:0] o_load_stall_cnt;
  logic [15:0] o_jmp_stall_cnt;
  logic [31:0] o_cycle_cnt;
  logic [3:0]  ctl;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_load_hazard    (i_load_hazard),
    .i_jmp_req        (i_jmp_req),
    .i_halt           (i_halt),
    .o_pc_wr_en       (o_pc_wr_en),
    .o_if_id_wr_en    (o_if_id_wr_en),
    .o_if_id_flush    (o_if_id_flush),
    .o_id_ex_bubble   (o_id_ex_bubble),
    .o_jmp_stop       (o_jmp_stop),
    .o_halted         (o_halted),
    .o_load_stall_cnt (o_load_stall_cnt),
    .o_jmp_stall_cnt  (o_jmp_stall_cnt),
    .o_cycle_cnt      (o_cycle_cnt)
  );

  // {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble}
  assign ctl = {o_pc_wr_en, o_if_id_wr_en, o_if_id_flush, o_id_ex_bubble};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the
  // combinational controls and the registered flags mid-cycle.
  task automatic cyc(input logic rst, input logic en, input logic ld,
                     input logic jmp, input logic hlt, input logic [3:0] exp_ctl,
                     input logic exp_js, input logic exp_h, input string tag);
    @(negedge i_clk);
    i_reset       = rst;
    i_enable      = en;
    i_load_hazard = ld;
    i_jmp_req     = jmp;
    i_halt        = hlt;
    #1;
    chk({tag, "_ctl"}, {28'd0, ctl}, {28'd0, exp_ctl});
    chk({tag, "_jmp_stop"}, {31'd0, o_jmp_stop}, {31'd0, exp_js});
    chk({tag, "_halted"}, {31'd0, o_halted}, {31'd0, exp_h});
  endtask

  task automatic chk_cnt(input string tag, input int ld, input int jm, input int cy);
    chk({tag, "_load_cnt"}, {16'd0, o_load_stall_cnt}, ld * CNT_ON);
    chk({tag, "_jmp_cnt"}, {16'd0, o_jmp_stall_cnt}, jm * CNT_ON);
    chk({tag, "_cycle_cnt"}, o_cycle_cnt, cy * CNT_ON);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_enable      = 1'b1;
    i_load_hazard = 1'b0;
    i_jmp_req     = 1'b0;
    i_halt        = 1'b0;

    // Reset with requests active and with enable low: controls all zero.
    cyc(1, 1, 1, 1, 1, 4'b0000, 0, 0, "rst_req");
    cyc(1, 0, 0, 0, 0, 4'b0000, 0, 0, "rst_dis");
    chk_cnt("rst", 0, 0, 0);

    // Five free-running cycles.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 4'b1100, 0, 0, "run");

    // Load hazard for two cycles: stall plus bubble exactly while high.
    cyc(0, 1, 1, 0, 0, 4'b0001, 0, 0, "ld1");
    chk_cnt("run5", 0, 0, 5);
    cyc(0, 1, 1, 0, 0, 4'b0001, 0, 0, "ld2");
    cyc(0, 1, 0, 0, 0, 4'b1100, 0, 0, "ld_end");
    chk_cnt("ld", 2, 0, 7);

    // Jump request: hold fetch, one cycle of jump-stop, requests ignored there.
    cyc(0, 1, 0, 1, 0, 4'b0000, 0, 0, "jmp");
    cyc(0, 1, 0, 1, 0, 4'b1100, 1, 0, "jwait");
    cyc(0, 1, 0, 0, 0, 4'b1100, 0, 0, "jback");
    chk_cnt("jmp", 2, 1, 10);

    // Frozen pipeline ignores a load hazard and counts nothing.
    cyc(0, 0, 1, 0, 0, 4'b0000, 0, 0, "dis_ld");
    chk_cnt("dis", 2, 1, 11);

    // Halt together with load hazard: halt wins, no bubble.
    cyc(0, 1, 1, 0, 1, 4'b0110, 0, 0, "halt");
    cyc(0, 1, 1, 1, 0, 4'b0110, 0, 0, "dr3");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 4'b0000, 0, 0, "frz");
    cyc(0, 1, 0, 0, 1, 4'b0110, 0, 0, "dr2");
    cyc(0, 1, 1, 0, 0, 4'b0110, 0, 0, "dr1");
    cyc(0, 1, 0, 1, 0, 4'b0110, 0, 0, "dr0");
    cyc(0, 1, 1, 1, 1, 4'b0000, 0, 1, "halted");
    cyc(0, 0, 0, 0, 0, 4'b0000, 0, 1, "halted_dis");
    cyc(0, 1, 0, 0, 0, 4'b0000, 0, 1, "halted_hold");
    chk_cnt("halted", 2, 1, 16);

    // Reset while halted: flag visible until the edge, then RUN resumes.
    cyc(1, 1, 0, 0, 0, 4'b0000, 0, 1, "rst_halted");
    cyc(0, 1, 0, 0, 0, 4'b1100, 0, 0, "after_rst");
    chk_cnt("after_rst", 0, 0, 0);

    // Load hazard outranks a simultaneous jump request: no jump-stop follows.
    cyc(0, 1, 1, 1, 0, 4'b0001, 0, 0, "ld_over_jmp");
    cyc(0, 1, 0, 0, 0, 4'b1100, 0, 0, "no_jstop");
    chk_cnt("prio", 1, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
